// File: rtl/fp32_normalize_round.sv
// fp32_normalize_round
//   Two-stage normalize-and-round back end for a binary32 adder.
//   S1 registers the raw adder result together with the leading-zero count
//   of the magnitude. S2 registers the normalized, round-to-nearest-even
//   result and its exception flags.
//
// Ports
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   in_valid/ready  : upstream handshake
//   in_sign         : result sign
//   in_exp          : biased exponent, valid when the leading one is at in_mant[30]
//   in_mant         : unnormalized magnitude (bit 31 carry-out, bits 6:0 extra precision)
//   in_special      : bypass select, in_special_val is passed through unchanged
//   in_special_val  : NaN/Inf/exact encoding from upstream
//   out_valid/ready : downstream handshake
//   out_result      : binary32 result
//   out_overflow, out_underflow, out_inexact : exception flags, valid with out_valid
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds valid and its data stable until that edge;
// ready may depend combinationally on the downstream ready.
module fp32_normalize_round (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [31:0] in_mant,
    input  logic        in_special,
    input  logic [31:0] in_special_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_underflow,
    output logic        out_inexact
);

    // Leading-zero count; an all-zero magnitude reports 31.
    function automatic logic [4:0] f_clz(input logic [31:0] m);
        logic [4:0] lz;
        lz = 5'd31;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) lz = 5'(31 - i);
        end
        return lz;
    endfunction

    // Stage 1 registers
    logic        r_s1_valid;
    logic        r_s1_sign;
    logic [7:0]  r_s1_exp;
    logic [31:0] r_s1_mant;
    logic [4:0]  r_s1_lz;
    logic        r_s1_special;
    logic [31:0] r_s1_special_val;

    // Stage 2 registers
    logic        r_s2_valid;
    logic [31:0] r_s2_result;
    logic        r_s2_overflow;
    logic        r_s2_underflow;
    logic        r_s2_inexact;

    logic        w_s2_free;
    logic [4:0]  w_in_lz;
    logic [4:0]  w_shamt;
    logic [30:0] w_norm;
    logic        w_drop;
    logic signed [9:0] w_exp_norm;
    logic        w_guard;
    logic        w_sticky;
    logic        w_round_up;
    logic [22:0] w_frac_rnd;
    logic        w_carry;
    logic signed [9:0] w_exp_final;
    logic [31:0] w_result;
    logic        w_overflow;
    logic        w_underflow;
    logic        w_inexact;

    assign w_s2_free = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_free;
    assign w_in_lz   = f_clz(in_mant);
    assign w_shamt   = r_s1_lz - 5'd1;

    // Normalize so the leading one sits at bit 30. When lz >= 1, bit 31 is
    // zero, so the left shift can work on the low 31 bits without loss.
    always_comb begin
        w_norm     = '0;
        w_drop     = 1'b0;
        w_exp_norm = '0;
        if (r_s1_lz == 5'd0) begin
            w_norm     = r_s1_mant[31:1];
            w_drop     = r_s1_mant[0];
            w_exp_norm = $signed({2'b00, r_s1_exp}) + 10'sd1;
        end else begin
            w_norm     = r_s1_mant[30:0] << w_shamt;
            w_exp_norm = $signed({2'b00, r_s1_exp}) - $signed({5'b00000, w_shamt});
        end
    end

    assign w_guard    = w_norm[6];
    assign w_sticky   = (|w_norm[5:0]) | w_drop;
    assign w_round_up = w_guard & (w_sticky | w_norm[7]);
    // The hidden bit is always 1 here, so a carry out of the fraction means
    // the significand reached 2^24: fraction wraps to 0, exponent bumps.
    assign w_frac_rnd = w_norm[29:7] + {22'd0, w_round_up};
    assign w_carry    = (&w_norm[29:7]) & w_round_up;
    assign w_exp_final = w_exp_norm + $signed({9'd0, w_carry});

    always_comb begin
        w_result    = '0;
        w_overflow  = 1'b0;
        w_underflow = 1'b0;
        w_inexact   = 1'b0;
        if (r_s1_special) begin
            w_result = r_s1_special_val;
        end else if (!w_norm[30]) begin
            // Leading one missing after normalization: magnitude was zero.
            w_result = 32'h0000_0000;
        end else if (w_exp_final >= 10'sd255) begin
            w_result   = {r_s1_sign, 8'hFF, 23'd0};
            w_overflow = 1'b1;
            w_inexact  = 1'b1;
        end else if (w_exp_final <= 10'sd0) begin
            w_result    = {r_s1_sign, 31'd0};
            w_underflow = 1'b1;
            w_inexact   = 1'b1;
        end else begin
            w_result  = {r_s1_sign, w_exp_final[7:0], w_frac_rnd};
            w_inexact = w_guard | w_sticky;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid       <= 1'b0;
            r_s1_sign        <= 1'b0;
            r_s1_exp         <= '0;
            r_s1_mant        <= '0;
            r_s1_lz          <= '0;
            r_s1_special     <= 1'b0;
            r_s1_special_val <= '0;
            r_s2_valid       <= 1'b0;
            r_s2_result      <= '0;
            r_s2_overflow    <= 1'b0;
            r_s2_underflow   <= 1'b0;
            r_s2_inexact     <= 1'b0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_sign        <= in_sign;
                    r_s1_exp         <= in_exp;
                    r_s1_mant        <= in_mant;
                    r_s1_lz          <= w_in_lz;
                    r_s1_special     <= in_special;
                    r_s1_special_val <= in_special_val;
                end
            end
            if (w_s2_free) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_result    <= w_result;
                    r_s2_overflow  <= w_overflow;
                    r_s2_underflow <= w_underflow;
                    r_s2_inexact   <= w_inexact;
                end
            end
        end
    end

    assign out_valid     = r_s2_valid;
    assign out_result    = r_s2_result;
    assign out_overflow  = r_s2_overflow;
    assign out_underflow = r_s2_underflow;
    assign out_inexact   = r_s2_inexact;

endmodule

// File: tb/tb_fp32_normalize_round.sv
// tb_fp32_normalize_round
//   Scoreboarded bench for fp32_normalize_round: directed vectors with
//   hand-computed results, backpressure and mid-flight reset scenarios, and
//   randomized traffic checked against a leading-one / exact-remainder model.
module tb_fp32_normalize_round;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [31:0] in_mant;
    logic        in_special;
    logic [31:0] in_special_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    fp32_normalize_round dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sign        (in_sign),
        .in_exp         (in_exp),
        .in_mant        (in_mant),
        .in_special     (in_special),
        .in_special_val (in_special_val),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_overflow   (out_overflow),
        .out_underflow  (out_underflow),
        .out_inexact    (out_inexact)
    );

    // ---------------- clock / reset / counters ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int pop_cnt = 0;
    bit lat_chk = 1'b0;
    bit rand_done = 1'b0;

    // expected {result, overflow, underflow, inexact}
    logic [34:0] exp_q[$];
    int          acc_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Value is in_mant * 2^(in_exp - 127 - 30). Locate the leading one,
    // keep 24 bits from it, and round the exact discarded remainder to
    // nearest-even by comparing against half an ulp.
    function automatic logic [34:0] model(input logic s, input logic [7:0] e,
                                          input logic [31:0] m, input logic sp,
                                          input logic [31:0] sv);
        int p;
        int be;
        int sh;
        longint unsigned kept;
        longint unsigned rem;
        longint unsigned half;
        logic inx;
        logic [7:0] be8;
        logic [22:0] frac;
        if (sp) return {sv, 3'b000};
        if (m == 32'd0) return 35'd0;
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        be = int'(e) + p - 30;
        if (p > 23) begin
            sh   = p - 23;
            kept = 64'(m) >> sh;
            rem  = 64'(m) & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            inx  = (rem != 0);
            if (rem > half || (rem == half && kept[0])) kept = kept + 1;
        end else begin
            kept = 64'(m) << (23 - p);
            inx  = 1'b0;
        end
        if (kept == (64'd1 << 24)) begin
            kept = 64'd1 << 23;
            be   = be + 1;
        end
        if (be >= 255) return {s, 8'hFF, 23'd0, 3'b101};
        if (be <= 0)   return {s, 31'd0, 3'b011};
        be8  = be[7:0];
        frac = kept[22:0];
        return {s, be8, frac, 2'b00, inx};
    endfunction

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the edge that
    // took the transfer, with in_valid low.
    task automatic send(input logic s, input logic [7:0] e, input logic [31:0] m,
                        input logic sp, input logic [31:0] sv, input logic [34:0] expv);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_sign = s;
        in_exp = e;
        in_mant = m;
        in_special = sp;
        in_special_val = sv;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                check("send_timeout", 64'd1, 64'd0);
                break;
            end
            @(posedge clk);
            #1;
        end
        if (waited <= 200) begin
            exp_q.push_back(expv);
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_dir(input logic s, input logic [7:0] e, input logic [31:0] m,
                            input logic [31:0] res, input logic [2:0] flags);
        send(s, e, m, 1'b0, 32'd0, {res, flags});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {29'd0, out_result, out_overflow, out_underflow, out_inexact}, 64'd0);
            end else begin
                check("out", {29'd0, out_result, out_overflow, out_underflow, out_inexact},
                      {29'd0, exp_q[0]});
                if (out_ready) begin
                    if (lat_chk) check("latency", 64'(cyc - acc_q[0]), 64'd2);
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    pop_cnt++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic        rs;
        logic [7:0]  re;
        logic [31:0] rm;
        logic        rsp;
        logic [31:0] rsv;
        int          pops_before;

        rst = 1'b1;
        in_valid = 1'b0;
        in_sign = 1'b0;
        in_exp = '0;
        in_mant = '0;
        in_special = 1'b0;
        in_special_val = '0;
        out_ready = 1'b1;

        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_flags", {61'd0, out_overflow, out_underflow, out_inexact}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors, streaming, out_ready high: latency must be 2.
        lat_chk = 1'b1;
        send_dir(1'b0, 8'd127, 32'h8000_0000, 32'h4000_0000, 3'b000); // carry
        send_dir(1'b0, 8'd127, 32'h0000_0040, 32'h3380_0000, 3'b000); // cancellation
        send_dir(1'b0, 8'd127, 32'h4000_0040, 32'h3F80_0000, 3'b001); // tie, even
        send_dir(1'b0, 8'd127, 32'h4000_00C0, 32'h3F80_0002, 3'b001); // tie, odd
        send_dir(1'b1, 8'd254, 32'h8000_0000, 32'hFF80_0000, 3'b101); // overflow
        send_dir(1'b0, 8'd10,  32'h0000_0001, 32'h0000_0000, 3'b011); // underflow
        send_dir(1'b1, 8'd77,  32'h0000_0000, 32'h0000_0000, 3'b000); // zero
        send(1'b1, 8'd3, 32'h1234_5678, 1'b1, 32'h7FC0_0001, {32'h7FC0_0001, 3'b000}); // bypass
        send_dir(1'b0, 8'd127, 32'h7FFF_FFC0, 32'h4000_0000, 3'b001); // round carry
        send_dir(1'b0, 8'd254, 32'h7FFF_FFC0, 32'h7F80_0000, 3'b101); // round to overflow
        send_dir(1'b0, 8'd254, 32'h4000_0000, 32'h7F00_0000, 3'b000); // max exp
        send_dir(1'b0, 8'd1,   32'h4000_0000, 32'h0080_0000, 3'b000); // min normal
        send_dir(1'b0, 8'd1,   32'h2000_0000, 32'h0000_0000, 3'b011); // just below
        send_dir(1'b0, 8'd127, 32'h8000_0001, 32'h4000_0000, 3'b001); // dropped bit
        drain();
        lat_chk = 1'b0;

        // Backpressure: two accepted, third stalls, then in-order release.
        out_ready = 1'b0;
        send_dir(1'b0, 8'd120, 32'h4000_0000, 32'h3C00_0000, 3'b000);
        send_dir(1'b1, 8'd121, 32'h4000_0000, 32'hBC80_0000, 3'b000);
        in_valid = 1'b1;
        in_sign = 1'b0;
        in_exp = 8'd122;
        in_mant = 32'h4000_0000;
        in_special = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        pops_before = pop_cnt;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(in_ready), 64'd1);
        exp_q.push_back({32'h3D00_0000, 3'b000});
        acc_q.push_back(cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("bp_one_per_cycle", 64'(pop_cnt - pops_before), 64'd3);
        drain();

        // Reset with both stages full.
        out_ready = 1'b0;
        send_dir(1'b0, 8'd127, 32'h4000_0000, 32'h3F80_0000, 3'b000);
        send_dir(1'b0, 8'd128, 32'h4000_0000, 32'h4000_0000, 3'b000);
        #1;
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        check("pre_rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_out_result", 64'(out_result), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post_rst_idle", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure.
        fork
            begin
                for (int n = 0; n < 400; n++) begin
                    rs  = 1'($urandom_range(0, 1));
                    re  = 8'($urandom_range(0, 255));
                    rsp = 1'b0;
                    rsv = $urandom;
                    case ($urandom_range(0, 5))
                        0: rm = $urandom;
                        1: rm = $urandom >> $urandom_range(0, 31);
                        2: rm = ($urandom & 32'h7FFF_FF80) | 32'h4000_0040;
                        3: rm = (($urandom & 32'hFFFF_FF80) | 32'h0000_0040) >> $urandom_range(0, 8);
                        4: rm = 32'(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255));
                        default: begin
                            rm  = $urandom;
                            rsp = 1'b1;
                        end
                    endcase
                    send(rs, re, rm, rsp, rsv, model(rs, re, rm, rsp, rsv));
                    if ($urandom_range(0, 4) == 0) begin
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp32_normalize_round.md
FP32_NORMALIZE_ROUND -- requirements
Module: fp32_normalize_round

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-002 rst  input  1  asynchronous active-high reset.
REQ-003 in_valid  input  1  upstream adder result valid.
REQ-004 in_ready  output  1  block accepts input this cycle.
REQ-005 in_sign  input  1  result sign.
REQ-006 in_exp  input  8  biased exponent, valid when the leading one is at in_mant[30].
REQ-007 in_mant  input  32  unnormalized magnitude; bit 31 is the carry-out, bits 6:0 hold guard/round/sticky precision.
REQ-008 in_special  input  1  bypass: in_special_val passes unchanged.
REQ-009 in_special_val  input  32  NaN/Inf/exact encoding from upstream.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts.
REQ-012 out_result  output  32  IEEE-754 binary32 result.
REQ-013 out_overflow, out_underflow, out_inexact  output  1 each  exception flags, valid with out_valid.

Function
REQ-014 Two register stages SHALL be used: S1 captures the inputs plus the leading-zero count lz (0..31, 31 for zero) of in_mant; S2 holds the normalized, rounded result.
REQ-015 Latency SHALL be 2 cycles from accepted input to out_valid while out_ready stays high; throughput SHALL be 1 per cycle.
REQ-016 A stage SHALL advance when it is empty or the next stage frees that cycle; in_ready = !S1_valid || S2 advancing; S2 frees when !out_valid || out_ready.
REQ-017 While out_valid=1 and out_ready=0, out_result and the flags SHALL hold stable; no transaction SHALL be dropped, duplicated or reordered.
REQ-018 Normalization: if lz=0, shift right 1 with the dropped bit ORed into sticky, and exp+1; otherwise shift left (lz-1), and exp-(lz-1).
REQ-019 Exponent arithmetic SHALL use at least 10-bit signed width so underflow below 0 cannot wrap.
REQ-020 After normalization, bits 30:7 form the 24-bit significand, bit 6 is guard, and sticky = |bits 5:0.
REQ-021 Rounding SHALL be round-to-nearest-even: increment when guard && (sticky || lsb).
REQ-022 out_inexact SHALL equal guard || sticky.
REQ-023 A rounding carry to 2^24 SHALL set the fraction to 0 and increment the exponent.
REQ-024 A final exp >= 255 SHALL give {sign, 8'hFF, 23'h0} with out_overflow=1 and out_inexact=1.
REQ-025 A final exp <= 0 SHALL flush to {sign, 31'h0} with out_underflow=1 and out_inexact=1; subnormals are not produced.
REQ-026 in_mant=0 with in_special=0 SHALL give 32'h00000000 with all flags 0.
REQ-027 in_special=1 SHALL pass in_special_val unchanged to out_result, with all flags 0 and the same latency.

Reset
REQ-028 rst SHALL immediately, without a clock, clear both stage valids: out_valid=0, out_result=0, all flags 0.
REQ-029 in_ready SHALL be 1 during reset.
REQ-030 Transactions in flight at reset SHALL be discarded and never emitted after reset release.

Verification
REQ-031 Carry: in_mant=32'h80000000, in_exp=127, sign 0 -> out_result 32'h40000000 two cycles later, flags 0.
REQ-032 Cancellation: in_mant=32'h00000040, in_exp=127 -> 32'h33800000, flags 0.
REQ-033 RNE ties: in_mant=32'h40000040, in_exp=127 -> 32'h3F800000, inexact=1; in_mant=32'h400000C0, in_exp=127 -> 32'h3F800002, inexact=1.
REQ-034 Limits:
- in_mant=32'h80000000, in_exp=254, sign 1 -> 32'hFF800000, overflow=1.
- in_mant=32'h00000001, in_exp=10 -> 32'h00000000, underflow=1.
REQ-035 Backpressure: out_ready=0 with 3 back-to-back inputs -> 2 accepted, then in_ready=0; on out_ready=1, results emerge in order, one per cycle, with none lost.
REQ-036 Reset mid-operation: assert rst with S1 and S2 both valid -> out_valid=0 before the next edge; no output after release until new input.
